// File: rtl/sample_channel_arbiter.sv
// sample_channel_arbiter
//   Round-robin arbiter that shares one sign-extension path among several ADC
//   sample channels. The winning sample is sign-extended, registered with its
//   channel tag and offered downstream on a valid/ready stream.
//
//   Optional feature macro: OVERRANGE_FLAG_EN
//     Adds the overRange output. The flag is registered with outData and is
//     set when the granted sample is the most-positive or most-negative input
//     code. Without the macro the port and its logic do not exist.
//
//   Ports
//     clk         rising-edge clock
//     rst         synchronous active-high reset
//     enable      1: grants allowed; 0: no new grants, held sample still drains
//     chValid     per-channel sample available
//     chData      packed samples, channel i at [i*IN +: IN]
//     chReady     one-hot or zero, channel i consumed this cycle (combinational)
//     outValid    output register holds a sample
//     outData     sign-extended sample
//     outChannel  source channel of outData
//     outReady    downstream accepts when outValid && outReady
//     overRange   (OVERRANGE_FLAG_EN only) sample was at full scale
module sample_channel_arbiter #(
  parameter int NUM_CHANNELS     = 4,
  parameter int INPUT_DATA_SIZE  = 14,
  parameter int OUTPUT_DATA_SIZE = 16,
  parameter int CHANNEL_ID_SIZE  = 2
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    enable,
  input  logic [NUM_CHANNELS-1:0]                 chValid,
  input  logic [NUM_CHANNELS*INPUT_DATA_SIZE-1:0] chData,
  output logic [NUM_CHANNELS-1:0]                 chReady,
  output logic                                    outValid,
  output logic [OUTPUT_DATA_SIZE-1:0]             outData,
  output logic [CHANNEL_ID_SIZE-1:0]              outChannel,
  input  logic                                    outReady
`ifdef OVERRANGE_FLAG_EN
  ,
  output logic                                    overRange
`endif
);

  localparam int EXT_W = OUTPUT_DATA_SIZE - INPUT_DATA_SIZE;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t                                           state;
  logic [CHANNEL_ID_SIZE-1:0]                       last_grant;
  logic [NUM_CHANNELS-1:0][OUTPUT_DATA_SIZE-1:0]    lane_ext;
  logic [CHANNEL_ID_SIZE-1:0]                       winner;
  logic                                             found;
  logic                                             load;
  logic                                             grant;
`ifdef OVERRANGE_FLAG_EN
  logic [NUM_CHANNELS-1:0]                          lane_ovr;
`endif

  // Per-lane sign extension (and full-scale detect) computed in parallel;
  // the arbiter result then just picks one lane.
  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_lane
    logic [INPUT_DATA_SIZE-1:0] d;
    assign d           = chData[g*INPUT_DATA_SIZE +: INPUT_DATA_SIZE];
    assign lane_ext[g] = {{EXT_W{d[INPUT_DATA_SIZE-1]}}, d};
`ifdef OVERRANGE_FLAG_EN
    assign lane_ovr[g] = (d == {1'b0, {(INPUT_DATA_SIZE-1){1'b1}}}) ||
                         (d == {1'b1, {(INPUT_DATA_SIZE-1){1'b0}}});
`endif
  end

  assign outValid = (state == FULL);

  // Reset gates load so chReady stays low while rst is asserted.
  assign load  = enable && !rst && (!outValid || outReady);
  assign grant = load && found;

  // Round-robin search starting one past the previous winner; invalid
  // channels are skipped within the same cycle.
  always_comb begin
    int idx;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int off = 1; off <= NUM_CHANNELS; off++) begin
      idx = (int'(last_grant) + off) % NUM_CHANNELS;
      if (!found && chValid[idx]) begin
        found  = 1'b1;
        winner = CHANNEL_ID_SIZE'(idx);
      end
    end
  end

  assign chReady = grant ? (NUM_CHANNELS'(1) << winner) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      outData    <= '0;
      outChannel <= '0;
      last_grant <= CHANNEL_ID_SIZE'(NUM_CHANNELS - 1);
`ifdef OVERRANGE_FLAG_EN
      overRange  <= 1'b0;
`endif
    end else begin
      case (state)
        EMPTY: if (grant) state <= FULL;
        FULL:  if (outReady && !grant) state <= EMPTY;
        default: state <= EMPTY;
      endcase
      if (grant) begin
        outData    <= lane_ext[winner];
        outChannel <= winner;
        last_grant <= winner;
`ifdef OVERRANGE_FLAG_EN
        overRange  <= lane_ovr[winner];
`endif
      end
    end
  end

endmodule

// File: tb/tb_sample_channel_arbiter.sv
// Directed bench for sample_channel_arbiter (4 channels, 14 -> 16 bits).
// Inputs change 1 time unit after a rising edge; chReady is sampled 1 unit
// later, registered outputs 1 unit after the next rising edge.
module tb_sample_channel_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [3:0]  chValid;
  logic [55:0] chData;
  logic [3:0]  chReady;
  logic        outValid;
  logic [15:0] outData;
  logic [1:0]  outChannel;
  logic        outReady;
`ifdef OVERRANGE_FLAG_EN
  logic        overRange;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sample_channel_arbiter #(
    .NUM_CHANNELS(4), .INPUT_DATA_SIZE(14), .OUTPUT_DATA_SIZE(16), .CHANNEL_ID_SIZE(2)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .chValid(chValid), .chData(chData),
    .chReady(chReady), .outValid(outValid), .outData(outData),
    .outChannel(outChannel), .outReady(outReady)
`ifdef OVERRANGE_FLAG_EN
    , .overRange(overRange)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [13:0] v);
    chData[ch*14 +: 14] = v;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [15:0] d, input logic [1:0] c);
    chk({tag, ".valid"}, 32'(outValid), 32'(v));
    chk({tag, ".data"},  32'(outData),  32'(d));
    chk({tag, ".chan"},  32'(outChannel), 32'(c));
  endtask

  logic [15:0] t1_exp [4] = '{16'h0001, 16'hFFFF, 16'hE000, 16'h1FFF};

  initial begin
    rst = 1'b1; enable = 1'b1; chValid = 4'hF; chData = '0; outReady = 1'b1;
    #1;
    chk("rst.ready", 32'(chReady), 32'h0);
    step(); step();
    chk_out("rst", 1'b0, 16'h0, 2'd0);
    chk("rst.ready2", 32'(chReady), 32'h0);

    // 1: all valid, round robin 0,1,2,3,0
    rst = 1'b0;
    set_ch(0, 14'h0001); set_ch(1, 14'h3FFF); set_ch(2, 14'h2000); set_ch(3, 14'h1FFF);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t1.ready", 32'(chReady), 32'(4'b0001 << (i % 4)));
      step();
      chk_out("t1", 1'b1, t1_exp[i % 4], 2'(i % 4));
    end

    // 2: single requester ch2 granted every cycle
    chValid = 4'b0100; set_ch(2, 14'h0123);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t2.ready", 32'(chReady), 32'h4);
      step();
      chk_out("t2", 1'b1, 16'h0123, 2'd2);
    end

    // park pointer on ch3 so the next search starts at ch0
    chValid = 4'b1000; set_ch(3, 14'h3000);
    #1;
    chk("t3.pre", 32'(chReady), 32'h8);
    step();
    chk_out("t3.pre", 1'b1, 16'hF000, 2'd3);

    // 3: ch0 and ch3 valid, stall after ch0 grant
    chValid = 4'b1001; set_ch(0, 14'h0AAA);
    #1;
    chk("t3.ready0", 32'(chReady), 32'h1);
    step();
    chk_out("t3.g0", 1'b1, 16'h0AAA, 2'd0);
    outReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t3.stall.ready", 32'(chReady), 32'h0);
      step();
      chk_out("t3.stall", 1'b1, 16'h0AAA, 2'd0);
    end
    outReady = 1'b1;
    #1;
    chk("t3.ready3", 32'(chReady), 32'h8);
    step();
    chk_out("t3.g3", 1'b1, 16'hF000, 2'd3);

    // 4: continuous traffic, then enable dropped while FULL
    chValid = 4'hF;
    set_ch(0, 14'h0001); set_ch(1, 14'h3FFF); set_ch(2, 14'h2000); set_ch(3, 14'h1FFF);
    step(); chk_out("t4.g0", 1'b1, 16'h0001, 2'd0);
    step(); chk_out("t4.g1", 1'b1, 16'hFFFF, 2'd1);
    enable = 1'b0; outReady = 1'b0;
    #1;
    chk("t4.dis.ready", 32'(chReady), 32'h0);
    step(); chk_out("t4.hold", 1'b1, 16'hFFFF, 2'd1);
    outReady = 1'b1;
    #1;
    chk("t4.drain.ready", 32'(chReady), 32'h0);
    step(); chk("t4.empty", 32'(outValid), 32'h0);
    step(); chk("t4.empty2", 32'(outValid), 32'h0);
    chk("t4.empty.ready", 32'(chReady), 32'h0);
    enable = 1'b1;
    #1;
    chk("t4.resume.ready", 32'(chReady), 32'h4);
    step(); chk_out("t4.resume", 1'b1, 16'hE000, 2'd2);

    // 5: reset while FULL with ch1 pending
    chValid = 4'b0010; outReady = 1'b0; rst = 1'b1;
    #1;
    chk("t5.rst.ready", 32'(chReady), 32'h0);
    step();
    chk_out("t5.rst", 1'b0, 16'h0, 2'd0);
    rst = 1'b0; chValid = 4'b0011; outReady = 1'b1;
    #1;
    chk("t5.first.ready", 32'(chReady), 32'h1);
    step(); chk_out("t5.first", 1'b1, 16'h0001, 2'd0);
    chk("t5.next.ready", 32'(chReady), 32'h2);
    step(); chk_out("t5.next", 1'b1, 16'hFFFF, 2'd1);
    chValid = 4'b0000;
    #1;
    chk("t5.idle.ready", 32'(chReady), 32'h0);
    step(); chk("t5.idle.valid", 32'(outValid), 32'h0);

`ifdef OVERRANGE_FLAG_EN
    // 6: full-scale flag
    begin
      logic [13:0] s [3] = '{14'h1FFF, 14'h2000, 14'h1FFE};
      logic [15:0] e [3] = '{16'h1FFF, 16'hE000, 16'h1FFE};
      logic        o [3] = '{1'b1, 1'b1, 1'b0};
      chValid = 4'b0001;
      for (int i = 0; i < 3; i++) begin
        set_ch(0, s[i]);
        step();
        chk_out("t6", 1'b1, e[i], 2'd0);
        chk("t6.ovr", 32'(overRange), 32'(o[i]));
      end
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
